id_stage_decoder: RTL and testbench
===================================

// Module: id_stage_decoder
// PURPOSE
//  Registered RV32I instruction-decode stage between IF and EX of the 5-stage pipeline.
//  Splits each fetched instruction into imm/rs1/rs2/rd/func3/func7/opcode, flags illegal
//  encodings, and carries the PC through. A 2-entry skid buffer with valid/ready on both
//  sides gives full throughput under EX back-pressure; flush kills in-flight entries.
// PARAMETERS
//  XLEN      32  datapath width (32 or 64); imm and pc are sign-/zero-extended to XLEN
//  RADDR_W    5  register-address width (5 = 32 GPRs)
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        synchronous reset, active-high
//  flush      in   1        drop all held entries (branch mispredict / trap)
//  in_valid   in   1        IF presents inst/pc
//  in_ready   out  1        stage can accept (registered)
//  in_inst    in   32       instruction word
//  in_pc      in   XLEN     instruction PC
//  out_valid  out  1        decoded entry available to EX
//  out_ready  in   1        EX accepts
//  imm        out  XLEN     sign-extended immediate
//  rs1,rs2,rd out  RADDR_W  register indices (0 when the format has no such field)
//  func3      out  3        ; func7 out 7 ; opcode out 7
//  out_pc     out  XLEN     PC of decoded instruction
//  illegal    out  1        encoding not supported
// BEHAVIOUR
//  - Reset: in_ready=1, out_valid=0, all data outputs 0, both skid entries empty.
//  - Transfer in on in_valid&in_ready; out on out_valid&out_ready. Latency 1 cycle
//    (inst accepted at edge N appears on outputs after edge N, i.e. cycle N+1).
//  - Main reg drives outputs; skid reg catches one entry when out_ready low and main full.
//    in_ready next = !skid_full_next. With skid full, out accept moves skid->main.
//    Simultaneous in/out accept with skid empty: main reloads, no skid use.
//  - Outputs held stable while out_valid & !out_ready.
//  - flush: both entries invalid next cycle, out_valid=0, in_ready=1; any in_valid in the
//    flush cycle is dropped. flush has priority over accepts; rst over flush.
//  - Decode (combinational on in_inst, registered on capture), opcode=inst[6:0]:
//    LUI/AUIPC imm={inst[31:12],12'b0}; JAL imm={inst[31],inst[19:12],inst[20],inst[30:21],0};
//    JALR/LOAD/OP-IMM imm=inst[31:20]; STORE imm={inst[31:25],inst[11:7]};
//    BRANCH imm={inst[31],inst[7],inst[30:25],inst[11:8],0}; all sign-extended to XLEN;
//    other opcodes imm=0.
//  - rs1 valid for JALR/BRANCH/LOAD/STORE/OP-IMM/OP; rs2 for BRANCH/STORE/OP; rd zero for
//    BRANCH/STORE; func3 zero where rs1 unused; func7=inst[31:25] only for OP, or OP-IMM
//    with func3[1:0]=01, else 0.
//  - illegal=1 for: opcode not in the nine RV32I majors; inst[1:0]!=11; JALR func3!=0;
//    BRANCH func3 010/011; LOAD func3 011/110/111; STORE func3>=011; OP func7 not 0000000
//    (or 0100000 with func3 000/101); OP-IMM shift func7 not 0000000/0100000(srai only).
//    Illegal entries still flow with fields decoded as above.
//  - out_pc = zero-extended in_pc captured with the instruction.
// CONFIGURATION
//  RV32M_EN defined: OP with func7=0000001 (MUL..REMU, any func3) is legal; func7 passed.
//  RV32M_EN undefined: that encoding sets illegal=1; fields still decoded.
// TESTING
//  1 addi x1,x2,-1 (0xFFF10093), out_ready=1 -> next cycle imm=0xFFFFFFFF, rs1=2, rd=1,
//    rs2=0, func3=0, illegal=0, out_valid=1.
//  2 sw x5,8(x2) (0x00512423) -> imm=8, rs1=2, rs2=5, rd=0, func3=2.
//  3 stream 4 insts with out_ready=0 -> in_ready drops after 2 accepted; raise out_ready ->
//    all 4 emerge in order, none lost/duplicated, back-to-back.
//  4 2 entries held, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1,
//    flushed and concurrent insts never appear.
//  5 mul x3,x1,x2 (0x022081B3) -> illegal=0 with RV32M_EN, 1 without; rs1=1, rs2=2,
//    rd=3, func7=0x01 either way.
//  6 0xFFFFFFFF and rst asserted mid-stream -> illegal=1; after rst all outputs 0,
//    out_valid=0, in_ready=1.

Source files
------------

// File: rtl/id_stage_decoder.sv
// RV32I decode stage: combinational field split registered behind a 2-entry skid buffer.
// Optional macro RV32M_EN makes the OP/func7=0000001 (M extension) encodings legal.
module id_stage_decoder #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_inst,
    input  logic [XLEN-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    imm,
    output logic [RADDR_W-1:0] rs1,
    output logic [RADDR_W-1:0] rs2,
    output logic [RADDR_W-1:0] rd,
    output logic [2:0]         func3,
    output logic [6:0]         func7,
    output logic [6:0]         opcode,
    output logic [XLEN-1:0]    out_pc,
    output logic               illegal
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef struct packed {
        logic [XLEN-1:0]    imm;
        logic [RADDR_W-1:0] rs1;
        logic [RADDR_W-1:0] rs2;
        logic [RADDR_W-1:0] rd;
        logic [2:0]         func3;
        logic [6:0]         func7;
        logic [6:0]         opcode;
        logic [XLEN-1:0]    pc;
        logic               illegal;
    } dec_t;

    dec_t               dec, main_q, skid_q;
    logic               main_v, skid_v;
    logic signed [31:0] imm32;
    logic               use_rs1, use_rs2, use_rd, keep_f7, known, bad;
    logic [6:0]         op, f7;
    logic [2:0]         f3;

    always_comb begin
        op      = in_inst[6:0];
        f3      = in_inst[14:12];
        f7      = in_inst[31:25];
        imm32   = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        keep_f7 = 1'b0;
        known   = 1'b1;
        bad     = 1'b0;
        case (op)
            OP_LUI, OP_AUIPC: begin
                imm32  = {in_inst[31:12], 12'b0};
                use_rd = 1'b1;
            end
            OP_JAL: begin
                imm32  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                          in_inst[30:21], 1'b0};
                use_rd = 1'b1;
            end
            OP_JALR: begin
                imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                bad     = (f3 != 3'b000);
            end
            OP_BRANCH: begin
                imm32   = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                           in_inst[11:8], 1'b0};
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                bad     = (f3[2:1] == 2'b01);
            end
            OP_LOAD: begin
                imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                bad     = (f3 == 3'b011) || (f3[2:1] == 2'b11);
            end
            OP_STORE: begin
                imm32   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                bad     = (f3 >= 3'b011);
            end
            OP_IMM: begin
                imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                // shifts: func7 qualifies shamt; only srai may use 0100000
                if (f3[1:0] == 2'b01) begin
                    keep_f7 = 1'b1;
                    bad     = f3[2] ? !(f7 == 7'b0000000 || f7 == 7'b0100000)
                                    : (f7 != 7'b0000000);
                end
            end
            OP_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
                keep_f7 = 1'b1;
                case (f7)
                    7'b0000000: bad = 1'b0;
                    7'b0100000: bad = !(f3 == 3'b000 || f3 == 3'b101);
`ifdef RV32M_EN
                    7'b0000001: bad = 1'b0;
`else
                    7'b0000001: bad = 1'b1;
`endif
                    default:    bad = 1'b1;
                endcase
            end
            default: known = 1'b0;
        endcase

        dec         = '0;
        dec.imm     = XLEN'(imm32);
        dec.rs1     = use_rs1 ? RADDR_W'(in_inst[19:15]) : '0;
        dec.rs2     = use_rs2 ? RADDR_W'(in_inst[24:20]) : '0;
        dec.rd      = use_rd  ? RADDR_W'(in_inst[11:7])  : '0;
        dec.func3   = use_rs1 ? f3 : 3'b000;
        dec.func7   = keep_f7 ? f7 : 7'b0000000;
        dec.opcode  = op;
        dec.pc      = in_pc;
        dec.illegal = !known || bad || (in_inst[1:0] != 2'b11);
    end

    // skid_v implies main_v; an occupied skid is the only thing that stalls IF
    always_ff @(posedge clk) begin
        if (rst) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (skid_v) begin
            if (out_ready) begin
                main_q <= skid_q;
                skid_v <= 1'b0;
            end
        end else if (!main_v || out_ready) begin
            main_v <= in_valid;
            if (in_valid) main_q <= dec;
        end else if (in_valid) begin
            skid_v <= 1'b1;
            skid_q <= dec;
        end
    end

    assign in_ready  = !skid_v;
    assign out_valid = main_v;
    assign imm       = main_q.imm;
    assign rs1       = main_q.rs1;
    assign rs2       = main_q.rs2;
    assign rd        = main_q.rd;
    assign func3     = main_q.func3;
    assign func7     = main_q.func7;
    assign opcode    = main_q.opcode;
    assign out_pc    = main_q.pc;
    assign illegal   = main_q.illegal;
endmodule

// File: tb/tb_id_stage_decoder.sv
// Directed scoreboard bench for id_stage_decoder: handshakes sampled on the falling edge,
// expected decodes pushed on input accept and popped on output accept.
module tb_id_stage_decoder;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic        in_ready, out_valid, illegal;
    logic [31:0] in_inst, in_pc, imm, out_pc;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  func3;
    logic [6:0]  func7, opcode;

    id_stage_decoder dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd), .func3(func3), .func7(func7),
        .opcode(opcode), .out_pc(out_pc), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [6:0]  f7, op;
        logic [31:0] pc;
        logic        ill;
    } rec_t;

`ifdef RV32M_EN
    localparam logic MUL_ILL = 1'b0;
`else
    localparam logic MUL_ILL = 1'b1;
`endif

    rec_t q[$];
    bit   qf[$];
    rec_t nxt;
    bit   nxt_full;
    bit   acc;
    int   ncmp = 0;
    int   nerr = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic rec_t mk(input logic [31:0] i, input logic [4:0] a, input logic [4:0] b,
                                input logic [4:0] d, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [6:0] op, input logic [31:0] pc, input logic ill);
        rec_t r;
        r = {i, a, b, d, f3, f7, op, pc, ill};
        return r;
    endfunction

    task automatic tick();
        rec_t got, e;
        bit   f;
        @(negedge clk);
        acc = 1'b0;
        if (rst || flush) begin
            q.delete();
            qf.delete();
        end else begin
            if (out_valid && out_ready) begin
                got = {imm, rs1, rs2, rd, func3, func7, opcode, out_pc, illegal};
                chk("sb_expected_output", 128'(q.size() != 0), 128'(1));
                if (q.size() != 0) begin
                    e = q.pop_front();
                    f = qf.pop_front();
                    if (f) chk("sb_entry", 128'(got), 128'(e));
                    else   chk("sb_op_illegal", 128'({got.op, got.ill}), 128'({e.op, e.ill}));
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(nxt);
                qf.push_back(nxt_full);
                acc = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] inst, input logic [31:0] pc, input rec_t e, input bit full);
        int n = 0;
        in_inst  = inst;
        in_pc    = pc;
        nxt      = e;
        nxt_full = full;
        in_valid = 1'b1;
        do begin
            tick();
            n++;
        end while (!acc && n < 20);
        chk("send_accepted", 128'(acc), 128'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 30) begin
            tick();
            n++;
        end
        chk("drain_empty", 128'(q.size()), 128'(0));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
        chk({tag, "_data"}, 128'({imm, rs1, rs2, rd, func3, func7, opcode, out_pc, illegal}), 128'(0));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0; nxt = '0; nxt_full = 1'b1;
        tick(); tick();
        chk_reset_state("reset");
        rst = 1'b0;
        tick();

        // addi x1,x2,-1 : one-cycle latency
        out_ready = 1'b1;
        send(32'hFFF10093, 32'h100, mk(32'hFFFFFFFF, 5'd2, 5'd0, 5'd1, 3'd0, 7'h00, 7'h13, 32'h100, 1'b0), 1'b1);
        chk("addi_latency_valid", 128'(out_valid), 128'(1));
        drain();

        // sw x5,8(x2)
        send(32'h00512423, 32'h104, mk(32'd8, 5'd2, 5'd5, 5'd0, 3'd2, 7'h00, 7'h23, 32'h104, 1'b0), 1'b1);
        drain();

        // stream under back-pressure: lui, beq -4, sub, jal
        out_ready = 1'b0;
        send(32'h123452B7, 32'h200, mk(32'h12345000, 5'd0, 5'd0, 5'd5, 3'd0, 7'h00, 7'h37, 32'h200, 1'b0), 1'b1);
        send(32'hFE208EE3, 32'h204, mk(32'hFFFFFFFC, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 7'h63, 32'h204, 1'b0), 1'b1);
        chk("stall_in_ready_low", 128'(in_ready), 128'(0));
        chk("stall_out_valid", 128'(out_valid), 128'(1));
        out_ready = 1'b1;
        send(32'h402081B3, 32'h208, mk(32'h0, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 7'h33, 32'h208, 1'b0), 1'b1);
        send(32'h008000EF, 32'h20C, mk(32'd8, 5'd0, 5'd0, 5'd1, 3'd0, 7'h00, 7'h6F, 32'h20C, 1'b0), 1'b1);
        drain();

        // flush with both entries held and a concurrent input
        out_ready = 1'b0;
        send(32'h00412203, 32'h300, mk(32'd4, 5'd2, 5'd0, 5'd4, 3'd2, 7'h00, 7'h03, 32'h300, 1'b0), 1'b1);
        send(32'h00812283, 32'h304, mk(32'd8, 5'd2, 5'd0, 5'd5, 3'd2, 7'h00, 7'h03, 32'h304, 1'b0), 1'b1);
        in_inst = 32'h00C12303; in_pc = 32'h308; in_valid = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 128'(out_valid), 128'(0));
        chk("flush_in_ready", 128'(in_ready), 128'(1));
        out_ready = 1'b1;
        send(32'hFF83A303, 32'h400, mk(32'hFFFFFFF8, 5'd7, 5'd0, 5'd6, 3'd2, 7'h00, 7'h03, 32'h400, 1'b0), 1'b1);
        drain();

        // mul, branch func3=010, slli with func7=0100000
        send(32'h022081B3, 32'h500, mk(32'h0, 5'd1, 5'd2, 5'd3, 3'd0, 7'h01, 7'h33, 32'h500, MUL_ILL), 1'b1);
        send(32'hFE20AEE3, 32'h504, mk(32'hFFFFFFFC, 5'd1, 5'd2, 5'd0, 3'd2, 7'h00, 7'h63, 32'h504, 1'b1), 1'b1);
        send(32'h40311093, 32'h508, mk(32'h00000403, 5'd2, 5'd0, 5'd1, 3'd1, 7'h20, 7'h13, 32'h508, 1'b1), 1'b1);
        drain();

        // all-ones word, then reset in mid-stream
        send(32'hFFFFFFFF, 32'h600, mk(32'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 7'h7F, 32'h600, 1'b1), 1'b0);
        drain();
        out_ready = 1'b0;
        send(32'hFFF10093, 32'h604, mk(32'hFFFFFFFF, 5'd2, 5'd0, 5'd1, 3'd0, 7'h00, 7'h13, 32'h604, 1'b0), 1'b1);
        send(32'h00512423, 32'h608, mk(32'd8, 5'd2, 5'd5, 5'd0, 3'd2, 7'h00, 7'h23, 32'h608, 1'b0), 1'b1);
        rst = 1'b1;
        tick();
        chk_reset_state("midrst");
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("post_rst_out_valid", 128'(out_valid), 128'(0));
        chk("post_rst_in_ready", 128'(in_ready), 128'(1));
        chk("final_queue_empty", 128'(q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
